skinny_sbox_layer_ctrl: RTL and testbench

Sequencer that applies the first-order masked (HPC2, two-share) Skinny 4-bit S-box to all 16 nibbles of a shared 64-bit state. It uses one externally instantiated, free-running pipelined S-box (LATENCY register stages, no enable) and streams one nibble per cycle through it. Each cycle it supplies the 4 fresh random bits, and it writes results back into a shared output state register. It sits between the round controller and the S-box instance, and owns the randomness handshake with the PRNG.

---
 rtl/skinny_ctrl_pkg.sv | 16 +
 rtl/sbox_token_pipe.sv | 39 +++
 rtl/skinny_sbox_layer_ctrl.sv | 153 +++++++++++++++
 tb/tb_skinny_sbox_layer_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/skinny_ctrl_pkg.sv
// rtl/skinny_ctrl_pkg.sv - shared types and constants for the masked Skinny S-box layer sequencer
package skinny_ctrl_pkg;

    localparam int NIBBLES      = 16;
    localparam int SBOX_LATENCY = 5;
    localparam int FRESH_W      = 4;

    typedef logic [3:0] nib_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

endpackage

// File: rtl/sbox_token_pipe.sv
// rtl/sbox_token_pipe.sv - valid/index tokens shadowing the external S-box pipeline
module sbox_token_pipe
    import skinny_ctrl_pkg::*;
#(
    parameter int LATENCY = SBOX_LATENCY
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     issue,
    input  nib_idx_t issue_idx,
    input  logic     squash,
    output logic     out_vld,
    output nib_idx_t out_idx
);

    logic [LATENCY:1] vld;
    nib_idx_t         idx [1:LATENCY];

    // Shift tokens along with the S-box; squash kills every token not yet at the output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int k = 1; k <= LATENCY; k++) begin
                idx[k] <= '0;
            end
        end else begin
            vld[1] <= issue;
            idx[1] <= issue_idx;
            for (int k = 2; k <= LATENCY; k++) begin
                vld[k] <= vld[k-1] & ~squash;
                idx[k] <= idx[k-1];
            end
        end
    end

    assign out_vld = vld[LATENCY];
    assign out_idx = idx[LATENCY];

endmodule

// File: rtl/skinny_sbox_layer_ctrl.sv
// rtl/skinny_sbox_layer_ctrl.sv - streams 16 shared nibbles through one masked S-box and collects results
module skinny_sbox_layer_ctrl #(
    parameter int LATENCY = skinny_ctrl_pkg::SBOX_LATENCY,
    parameter int NIBBLES = skinny_ctrl_pkg::NIBBLES,
    parameter int RND_W   = skinny_ctrl_pkg::FRESH_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] state_in_s0,
    input  logic [4*NIBBLES-1:0] state_in_s1,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] state_out_s0,
    output logic [4*NIBBLES-1:0] state_out_s1,
    input  logic [RND_W-1:0]     rnd_in,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    output logic [3:0]           sbox_x_s0,
    output logic [3:0]           sbox_x_s1,
    output logic [RND_W-1:0]     sbox_fresh,
    input  logic [3:0]           sbox_y_s0,
    input  logic [3:0]           sbox_y_s1
);
    import skinny_ctrl_pkg::fsm_t;
    import skinny_ctrl_pkg::nib_idx_t;
    import skinny_ctrl_pkg::IDLE;
    import skinny_ctrl_pkg::RUN;
    import skinny_ctrl_pkg::DONE;

    localparam int               PTR_W    = $clog2(NIBBLES + 1);
    localparam int               IDX_W    = $bits(nib_idx_t);
    localparam logic [PTR_W-1:0] NIB_CNT  = PTR_W'(NIBBLES);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NIBBLES - 1);

    fsm_t                 state;
    fsm_t                 state_nxt;
    logic [4*NIBBLES-1:0] in_s0;
    logic [4*NIBBLES-1:0] in_s1;
    logic [PTR_W-1:0]     ptr_iss;
    logic [PTR_W-1:0]     ptr_wr;
    logic                 in_run;
    logic                 issue;
    logic                 squash;
    logic                 pipe_vld;
    logic                 wr_en;
    nib_idx_t             iss_idx;
    nib_idx_t             wr_idx;

    assign in_run  = (state == RUN);
    assign issue   = in_run && rnd_valid && (ptr_iss < NIB_CNT);
    assign squash  = in_run && !rnd_valid;
    assign iss_idx = ptr_iss[IDX_W-1:0];
    assign wr_en   = in_run && pipe_vld;

    sbox_token_pipe #(
        .LATENCY (LATENCY)
    ) u_token_pipe (
        .clk       (clk),
        .rst       (rst),
        .issue     (issue),
        .issue_idx (iss_idx),
        .squash    (squash),
        .out_vld   (pipe_vld),
        .out_idx   (wr_idx)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and status outputs; DONE is entered on the edge that writes the last nibble
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rnd_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                rnd_ready = 1'b1;
                if (wr_en && (ptr_wr == LAST_IDX)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // S-box inputs are zero unless a nibble is issued; fresh bits only pass through when consumed
    always_comb begin
        sbox_x_s0  = '0;
        sbox_x_s1  = '0;
        sbox_fresh = '0;
        if (issue) begin
            sbox_x_s0 = in_s0[4*iss_idx +: 4];
            sbox_x_s1 = in_s1[4*iss_idx +: 4];
        end
        if (rnd_ready && rnd_valid) begin
            sbox_fresh = rnd_in;
        end
    end

    // Input latch and pointers; a starved cycle rewinds issue to the next nibble still to be written
    always_ff @(posedge clk) begin
        if (rst) begin
            in_s0   <= '0;
            in_s1   <= '0;
            ptr_iss <= '0;
            ptr_wr  <= '0;
        end else if ((state == IDLE) && start) begin
            in_s0   <= state_in_s0;
            in_s1   <= state_in_s1;
            ptr_iss <= '0;
            ptr_wr  <= '0;
        end else if (in_run) begin
            if (wr_en) begin
                ptr_wr <= ptr_wr + 1'b1;
            end
            if (!rnd_valid) begin
                ptr_iss <= ptr_wr + PTR_W'(wr_en);
            end else if (issue) begin
                ptr_iss <= ptr_iss + 1'b1;
            end
        end
    end

    // Result write-back, one nibble per S-box output token, both shares kept separate
    always_ff @(posedge clk) begin
        if (rst) begin
            state_out_s0 <= '0;
            state_out_s1 <= '0;
        end else if (wr_en) begin
            state_out_s0[4*wr_idx +: 4] <= sbox_y_s0;
            state_out_s1[4*wr_idx +: 4] <= sbox_y_s1;
        end
    end

endmodule

// File: tb/tb_skinny_sbox_layer_ctrl.sv
// tb/tb_skinny_sbox_layer_ctrl.sv - randomized self-checking bench for skinny_sbox_layer_ctrl
module tb_skinny_sbox_layer_ctrl;

    localparam int LAT = 5;
    localparam int NIB = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] state_in_s0;
    logic [63:0] state_in_s1;
    logic        busy;
    logic        done;
    logic [63:0] state_out_s0;
    logic [63:0] state_out_s1;
    logic [3:0]  rnd_in;
    logic        rnd_valid;
    logic        rnd_ready;
    logic [3:0]  sbox_x_s0;
    logic [3:0]  sbox_x_s1;
    logic [3:0]  sbox_fresh;
    logic [3:0]  sbox_y_s0;
    logic [3:0]  sbox_y_s1;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] prev_res;
    int          dc;

    always #5 clk = ~clk;

    skinny_sbox_layer_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .state_in_s0  (state_in_s0),
        .state_in_s1  (state_in_s1),
        .busy         (busy),
        .done         (done),
        .state_out_s0 (state_out_s0),
        .state_out_s1 (state_out_s1),
        .rnd_in       (rnd_in),
        .rnd_valid    (rnd_valid),
        .rnd_ready    (rnd_ready),
        .sbox_x_s0    (sbox_x_s0),
        .sbox_x_s1    (sbox_x_s1),
        .sbox_fresh   (sbox_fresh),
        .sbox_y_s0    (sbox_y_s0),
        .sbox_y_s1    (sbox_y_s1)
    );

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: return 4'hc;  4'h1: return 4'h6;  4'h2: return 4'h9;  4'h3: return 4'h0;
            4'h4: return 4'h1;  4'h5: return 4'ha;  4'h6: return 4'h2;  4'h7: return 4'hb;
            4'h8: return 4'h3;  4'h9: return 4'h8;  4'ha: return 4'h5;  4'hb: return 4'hd;
            4'hc: return 4'h4;  4'hd: return 4'he;  4'he: return 4'h7;  default: return 4'hf;
        endcase
    endfunction

    function automatic logic [63:0] layer(input logic [63:0] v);
        logic [63:0] r;
        r = '0;
        for (int n = 0; n < NIB; n++) r[4*n +: 4] = sbox4(v[4*n +: 4]);
        return r;
    endfunction

    // Pipelined masked S-box stand-in; a token that sits in stages 1..LAT-1 during a starved cycle is corrupted
    logic [3:0] sb_x [1:LAT];
    logic [3:0] sb_f [1:LAT];
    logic       sb_p [1:LAT];
    always @(posedge clk) begin
        sb_x[1] <= sbox_x_s0 ^ sbox_x_s1;
        sb_f[1] <= sbox_fresh;
        sb_p[1] <= 1'b0;
        for (int k = 2; k <= LAT; k++) begin
            sb_x[k] <= sb_x[k-1];
            sb_f[k] <= sb_f[k-1];
            sb_p[k] <= sb_p[k-1] | ~rnd_valid;
        end
    end
    assign sbox_y_s1 = sb_f[LAT];
    assign sbox_y_s0 = sbox4(sb_x[LAT]) ^ sb_f[LAT] ^ {4{sb_p[LAT]}};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // mode 0: randomness always valid, 1: starved in cycles 8 and 9, 2: random starvation
    task automatic run_layer(input logic [63:0] a0, input logic [63:0] a1, input int mode,
                             input bit pulse, input int abort_at, output int done_c);
        logic [63:0] res, exp_part, in0, in1;
        logic [3:0]  ex0, ex1, efr;
        int          nxt, nwr, exp_iss;
        bit          fin, rv;
        int          qt[$];
        res    = layer(a0 ^ a1);
        in0    = a0;
        in1    = a1;
        nxt    = 0;
        nwr    = 0;
        fin    = 1'b0;
        done_c = -1;
        @(posedge clk); #1;
        start       = 1'b1;
        state_in_s0 = a0;
        state_in_s1 = a1;
        rnd_valid   = 1'($urandom_range(0, 1));
        rnd_in      = 4'($urandom);
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_sbox_x", 64'({sbox_x_s0, sbox_x_s1}), 64'(0));
        check("idle_rnd_ready", 64'(rnd_ready), 64'(0));
        check("idle_fresh", 64'(sbox_fresh), 64'(0));
        for (int c = 1; c < 300; c++) begin
            @(posedge clk); #1;
            if (c == abort_at) begin
                rst   = 1'b1;
                start = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                check("abort_outputs", 64'({busy, done, rnd_ready, sbox_x_s0, sbox_x_s1, sbox_fresh}), 64'(0));
                check("abort_out_s0", state_out_s0, 64'(0));
                check("abort_out_s1", state_out_s1, 64'(0));
                prev_res = '0;
                repeat (30) begin
                    @(negedge clk);
                    check("abort_no_done", 64'({done, busy}), 64'(0));
                end
                return;
            end
            rv        = (mode == 0) ? 1'b1 : (mode == 1) ? !(c == 8 || c == 9) : ($urandom_range(0, 3) != 0);
            rnd_valid = rv;
            rnd_in    = 4'($urandom);
            start     = pulse && (c == 10 || fin);
            if (start) begin
                state_in_s0 = {$urandom, $urandom};
                state_in_s1 = {$urandom, $urandom};
            end
            exp_part = prev_res;
            for (int n = 0; n < nwr; n++) exp_part[4*n +: 4] = res[4*n +: 4];
            exp_iss = -1;
            if (!fin) begin
                if (qt.size() > 0 && qt[0] == c - LAT) begin
                    void'(qt.pop_front());
                    nwr++;
                end
                if (rv && nxt < NIB) exp_iss = nxt;
                if (!rv) begin
                    qt.delete();
                    nxt = nwr;
                end
                if (exp_iss >= 0) begin
                    qt.push_back(c);
                    nxt++;
                end
            end
            ex0 = (exp_iss >= 0) ? in0[4*exp_iss +: 4] : 4'h0;
            ex1 = (exp_iss >= 0) ? in1[4*exp_iss +: 4] : 4'h0;
            efr = (!fin && rv) ? rnd_in : 4'h0;
            @(negedge clk);
            check("busy", 64'(busy), 64'(!fin));
            check("done", 64'(done), 64'(fin));
            check("rnd_ready", 64'(rnd_ready), 64'(!fin));
            check("sbox_x_s0", 64'(sbox_x_s0), 64'(ex0));
            check("sbox_x_s1", 64'(sbox_x_s1), 64'(ex1));
            check("sbox_fresh", 64'(sbox_fresh), 64'(efr));
            check("partial_out", state_out_s0 ^ state_out_s1, exp_part);
            if (fin) begin
                done_c = c;
                break;
            end
            if (nwr == NIB) fin = 1'b1;
        end
        if (done_c < 0) check("done_timeout", 64'(done_c), 64'(0));
        @(posedge clk); #1;
        start     = 1'b0;
        rnd_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("post_busy", 64'({busy, done}), 64'(0));
        check("held_result", state_out_s0 ^ state_out_s1, res);
        prev_res = res;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        state_in_s0 = '0;
        state_in_s1 = '0;
        rnd_in      = '0;
        rnd_valid   = 1'b0;
        prev_res    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_status", 64'({busy, done, rnd_ready}), 64'(0));
        check("rst_sbox", 64'({sbox_x_s0, sbox_x_s1, sbox_fresh}), 64'(0));
        check("rst_out_s0", state_out_s0, 64'(0));
        check("rst_out_s1", state_out_s1, 64'(0));
        rst = 1'b0;

        run_layer(64'h0123456789ABCDEF, 64'h0, 0, 1'b0, -1, dc);
        check("t1_done_cycle", 64'(dc), 64'(22));
        check("t1_result", state_out_s0 ^ state_out_s1, 64'hC6901A2B385D4E7F);

        run_layer(64'h0123456789ABCDEF ^ 64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A5A5, 0, 1'b0, -1, dc);
        check("t2_done_cycle", 64'(dc), 64'(22));
        check("t2_result", state_out_s0 ^ state_out_s1, 64'hC6901A2B385D4E7F);

        run_layer({$urandom, $urandom}, {$urandom, $urandom}, 1, 1'b0, -1, dc);
        check("t3_stall_done_cycle", 64'(dc), 64'(28));

        run_layer({$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b1, -1, dc);
        check("t4_pulse_done_cycle", 64'(dc), 64'(22));

        run_layer({$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0, 12, dc);
        run_layer(64'h0123456789ABCDEF, 64'h0, 0, 1'b0, -1, dc);
        check("t5_restart_done_cycle", 64'(dc), 64'(22));

        for (int r = 0; r < 6; r++) begin
            run_layer({$urandom, $urandom}, {$urandom, $urandom}, 2, r[0], -1, dc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
